// File: rtl/nor_bank.sv
// nor_bank: a bank of independent, clocked NOR gates with per-channel
// oscillation detection. Inputs are sampled on the falling clock edge. The
// NOR results pass through a STAGES-deep delay line that advances on the
// rising edge. A saturating toggle counter per channel flags outputs that
// keep changing on consecutive rising edges.

module nor_bank #(
    parameter int unsigned         CHANNELS  = 8,
    parameter int unsigned         FANIN     = 3,
    parameter int unsigned         STAGES    = 1,
    parameter logic [CHANNELS-1:0] IV        = {CHANNELS{1'b0}},
    parameter int unsigned         OSC_LIMIT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*FANIN-1:0] a,
    input  logic                      freeze,
    input  logic                      osc_clr,
    output logic [CHANNELS-1:0]       y,
    output logic [CHANNELS-1:0]       osc
);

    localparam int unsigned TW = $clog2(OSC_LIMIT + 1);
    localparam logic [TW-1:0] LIM = TW'(OSC_LIMIT);

    logic [CHANNELS-1:0]               s_q, s_d;
    logic [STAGES-1:0][CHANNELS-1:0]   pipe_q, pipe_d;
    logic [CHANNELS-1:0][TW-1:0]       t_q, t_d;
    logic [CHANNELS-1:0]               osc_q, osc_d;
    logic [CHANNELS-1:0]               toggle;

    // Per-channel NOR of that channel's input slice
    always_comb begin
        s_d = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            s_d[c] = ~|a[c*FANIN +: FANIN];
        end
    end

    // Sample register: captures the NOR results on every falling edge
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            s_q <= IV;
        end else begin
            s_q <= s_d;
        end
    end

    // Delay line shift; the last stage is the visible output
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = s_q;
        for (int unsigned i = 1; i < STAGES; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign toggle = pipe_d[STAGES-1] ^ pipe_q[STAGES-1];

    // Toggle counters and sticky flags; a clear beats both freeze and a limit hit
    always_comb begin
        t_d   = t_q;
        osc_d = osc_q;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (osc_clr) begin
                t_d[c]   = '0;
                osc_d[c] = 1'b0;
            end else if (!freeze) begin
                if (toggle[c]) begin
                    t_d[c] = (t_q[c] == LIM) ? t_q[c] : t_q[c] + 1'b1;
                end else begin
                    t_d[c] = '0;
                end
                if (t_d[c] == LIM) begin
                    osc_d[c] = 1'b1;
                end
            end
        end
    end

    // Delay line advances only while not frozen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= {STAGES{IV}};
        end else if (!freeze) begin
            pipe_q <= pipe_d;
        end
    end

    // Oscillation tracking state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q   <= '0;
            osc_q <= '0;
        end else begin
            t_q   <= t_d;
            osc_q <= osc_d;
        end
    end

    assign y   = pipe_q[STAGES-1];
    assign osc = osc_q;

endmodule

// File: tb/tb_nor_bank.sv
// Directed testbench for nor_bank using three instances:
// u0 uses the defaults with IV=8'hA5, u1 uses STAGES=3, and
// u2 uses FANIN=1 and OSC_LIMIT=4 with an optional ring on channel 2.

module tb_nor_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // u0: defaults, IV = A5
    logic        rst0, fr0, clr0;
    logic [23:0] a0;
    logic [7:0]  y0, osc0;

    // u1: STAGES = 3
    logic        rst1, fr1, clr1;
    logic [23:0] a1;
    logic [7:0]  y1, osc1;

    // u2: FANIN = 1, OSC_LIMIT = 4, channel 2 can be looped back
    logic        rst2, fr2, clr2, ring_en;
    logic [7:0]  a2_drv, a2, y2, osc2;

    assign a2 = ring_en ? ((a2_drv & 8'hFB) | (y2 & 8'h04)) : a2_drv;

    nor_bank #(.CHANNELS(8), .FANIN(3), .STAGES(1), .IV(8'hA5), .OSC_LIMIT(15)) u0 (
        .clk(clk), .rst(rst0), .a(a0), .freeze(fr0), .osc_clr(clr0), .y(y0), .osc(osc0)
    );

    nor_bank #(.CHANNELS(8), .FANIN(3), .STAGES(3), .IV(8'h00), .OSC_LIMIT(15)) u1 (
        .clk(clk), .rst(rst1), .a(a1), .freeze(fr1), .osc_clr(clr1), .y(y1), .osc(osc1)
    );

    nor_bank #(.CHANNELS(8), .FANIN(1), .STAGES(1), .IV(8'h00), .OSC_LIMIT(4)) u2 (
        .clk(clk), .rst(rst2), .a(a2), .freeze(fr2), .osc_clr(clr2), .y(y2), .osc(osc2)
    );

    logic [23:0] pat_a [6];
    logic [7:0]  pat_y [6];
    logic [23:0] frz_a [5];
    logic        gap_a [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (y0 !== 8'hA5) $display("FAIL reset_y: got %h want %h", y0, 8'hA5);
        else passes++;
        checks++;
        if (osc0 !== 8'h00) $display("FAIL reset_osc: got %h want %h", osc0, 8'h00);
        else passes++;
        tick();
        tick();
        checks++;
        if (y0 !== 8'hA5) $display("FAIL reset_hold_y: got %h want %h", y0, 8'hA5);
        else passes++;
        rst0 = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (y0 !== 8'hA5) $display("FAIL release_negedge_y: got %h want %h", y0, 8'hA5);
        else passes++;
        tick();
        checks++;
        if (y0 !== 8'hFF) $display("FAIL release_first_y: got %h want %h", y0, 8'hFF);
        else passes++;
    endtask

    task automatic test_patterns();
        for (int i = 0; i < 6; i++) begin
            a0 = pat_a[i];
            tick();
            checks++;
            if (y0 !== pat_y[i])
                $display("FAIL pattern_%0d: a=%h got %h want %h", i, pat_a[i], y0, pat_y[i]);
            else passes++;
        end
    endtask

    task automatic test_rst_freeze();
        a0 = 24'hFFFFFF;
        tick();
        checks++;
        if (y0 !== 8'h00) $display("FAIL rf_pre_y: got %h want %h", y0, 8'h00);
        else passes++;
        fr0 = 1'b1;
        a0  = 24'h000000;
        tick();
        tick();
        checks++;
        if (y0 !== 8'h00) $display("FAIL rf_frozen_y: got %h want %h", y0, 8'h00);
        else passes++;
        @(negedge clk);
        #1;
        rst0 = 1'b1;
        #1;
        checks++;
        if (y0 !== 8'hA5) $display("FAIL rf_async_y: got %h want %h", y0, 8'hA5);
        else passes++;
        checks++;
        if (osc0 !== 8'h00) $display("FAIL rf_async_osc: got %h want %h", osc0, 8'h00);
        else passes++;
        tick();
        checks++;
        if (y0 !== 8'hA5) $display("FAIL rf_in_reset_y: got %h want %h", y0, 8'hA5);
        else passes++;
        a0   = 24'hFFFFFF;
        fr0  = 1'b0;
        rst0 = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (y0 !== 8'hA5) $display("FAIL rf_no_stale_y: got %h want %h", y0, 8'hA5);
        else passes++;
        tick();
        checks++;
        if (y0 !== 8'h00) $display("FAIL rf_after_y: got %h want %h", y0, 8'h00);
        else passes++;
    endtask

    task automatic test_latency();
        rst1 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (y1 !== 8'hFF) $display("FAIL lat_fill_y: got %h want %h", y1, 8'hFF);
        else passes++;
        a1 = 24'h000001;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (y1 !== ((k == 3) ? 8'hFE : 8'hFF))
                $display("FAIL lat_edge_%0d: got %h want %h", k, y1,
                         (k == 3) ? 8'hFE : 8'hFF);
            else passes++;
        end
    endtask

    task automatic test_freeze();
        for (int i = 0; i < 5; i++) begin
            a1  = frz_a[i];
            fr1 = 1'b1;
            tick();
            checks++;
            if (y1 !== 8'hFE) $display("FAIL frz_hold_%0d: got %h want %h", i, y1, 8'hFE);
            else passes++;
        end
        fr1 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (y1 !== ((k == 3) ? 8'hF7 : 8'hFE))
                $display("FAIL frz_resume_%0d: got %h want %h", k, y1,
                         (k == 3) ? 8'hF7 : 8'hFE);
            else passes++;
        end
    endtask

    task automatic test_ring();
        rst2 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (y2 !== 8'hFF) $display("FAIL ring_init_y: got %h want %h", y2, 8'hFF);
        else passes++;
        checks++;
        if (osc2 !== 8'h00) $display("FAIL ring_init_osc: got %h want %h", osc2, 8'h00);
        else passes++;
        ring_en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (y2 !== ((k % 2 == 1) ? 8'hFB : 8'hFF))
                $display("FAIL ring_y_%0d: got %h want %h", k, y2,
                         (k % 2 == 1) ? 8'hFB : 8'hFF);
            else passes++;
            checks++;
            if (osc2 !== ((k == 4) ? 8'h04 : 8'h00))
                $display("FAIL ring_osc_%0d: got %h want %h", k, osc2,
                         (k == 4) ? 8'h04 : 8'h00);
            else passes++;
        end
        tick();
        tick();
        checks++;
        if (osc2 !== 8'h04) $display("FAIL ring_sticky: got %h want %h", osc2, 8'h04);
        else passes++;
        clr2 = 1'b1;
        tick();
        checks++;
        if (osc2 !== 8'h00) $display("FAIL ring_clr: got %h want %h", osc2, 8'h00);
        else passes++;
        clr2 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (osc2 !== ((k == 4) ? 8'h04 : 8'h00))
                $display("FAIL ring_reflag_%0d: got %h want %h", k, osc2,
                         (k == 4) ? 8'h04 : 8'h00);
            else passes++;
        end
    endtask

    task automatic test_osc_gap();
        logic [7:0] exp_y;
        ring_en = 1'b0;
        tick();
        tick();
        fr2  = 1'b1;
        clr2 = 1'b1;
        tick();
        checks++;
        if (osc2 !== 8'h00) $display("FAIL gap_clr_frozen: got %h want %h", osc2, 8'h00);
        else passes++;
        fr2  = 1'b0;
        clr2 = 1'b0;
        tick();
        checks++;
        if (y2 !== 8'hFF) $display("FAIL gap_settle_y: got %h want %h", y2, 8'hFF);
        else passes++;
        // 3 toggles, one idle edge, 3 toggles: no flag; one more toggle flags
        for (int i = 0; i < 8; i++) begin
            a2_drv[0] = gap_a[i];
            tick();
            exp_y = {7'h7F, ~gap_a[i]};
            checks++;
            if (y2 !== exp_y) $display("FAIL gap_y_%0d: got %h want %h", i, y2, exp_y);
            else passes++;
            checks++;
            if (osc2 !== ((i == 7) ? 8'h01 : 8'h00))
                $display("FAIL gap_osc_%0d: got %h want %h", i, osc2,
                         (i == 7) ? 8'h01 : 8'h00);
            else passes++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        pat_a = '{24'h000001, 24'h000E00, 24'h200000, 24'h000010, 24'h249249, 24'h000000};
        pat_y = '{8'hFE, 8'hF7, 8'h7F, 8'hFD, 8'h00, 8'hFF};
        frz_a = '{24'hFFFFFF, 24'h000000, 24'h249249, 24'h000000, 24'h000E00};
        gap_a = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        rst0 = 1'b1; fr0 = 1'b0; clr0 = 1'b0; a0 = '0;
        rst1 = 1'b1; fr1 = 1'b0; clr1 = 1'b0; a1 = '0;
        rst2 = 1'b1; fr2 = 1'b0; clr2 = 1'b0; a2_drv = '0; ring_en = 1'b0;

        test_reset();
        test_patterns();
        test_rst_freeze();
        test_latency();
        test_freeze();
        test_ring();
        test_osc_gap();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
